// File: rtl/rptr_handler_if.sv
// rtl/rptr_handler_if.sv - read-side FIFO pointer/flag bus
// Purpose: groups the read-request, synchronised write pointer and all
//          read-side status outputs of rptr_handler.
// Ports (signals):
//   rinc          read request                      (master -> slave)
//   rq2_wptr      Gray write pointer, rclk domain   (master -> slave)
//   raddr         binary read address               (slave -> master)
//   rptr          registered Gray read pointer      (slave -> master)
//   rempty        registered empty flag             (slave -> master)
//   ralmost_empty registered almost-empty flag      (slave -> master)
//   rlevel        registered fill level             (slave -> master)
//   rvalid        read accepted on previous edge    (slave -> master)
//   runderflow    sticky read-while-empty flag      (slave -> master)
interface rptr_handler_if #(
  parameter int PTR_WIDTH = 3
);
  logic                 rinc;
  logic [PTR_WIDTH:0]   rq2_wptr;
  logic [PTR_WIDTH-1:0] raddr;
  logic [PTR_WIDTH:0]   rptr;
  logic                 rempty;
  logic                 ralmost_empty;
  logic [PTR_WIDTH:0]   rlevel;
  logic                 rvalid;
  logic                 runderflow;

  modport master (
    output rinc, rq2_wptr,
    input  raddr, rptr, rempty, ralmost_empty, rlevel, rvalid, runderflow
  );

  modport slave (
    input  rinc, rq2_wptr,
    output raddr, rptr, rempty, ralmost_empty, rlevel, rvalid, runderflow
  );
endinterface

// File: rtl/rptr_handler.sv
// rtl/rptr_handler.sv - async FIFO read-domain pointer and flag handler
// Purpose: keeps the binary read pointer, publishes a registered Gray read
//          pointer and derives registered empty/almost-empty/level/valid/
//          underflow status from the synchronised Gray write pointer.
// Ports:
//   rclk  read-domain clock
//   rrst  asynchronous active-high reset
//   bus   rptr_handler_if slave modport (rinc, rq2_wptr in; status out)
module rptr_handler #(
  parameter int PTR_WIDTH = 3,
  parameter int AE_THRESH = 2
) (
  input  logic          rclk,
  input  logic          rrst,
  rptr_handler_if.slave bus
);

  localparam int PW = PTR_WIDTH;
  localparam logic [PW:0] AE_LIMIT = (PW + 1)'(AE_THRESH);

  logic [PW:0] rbin_q, rbin_d;
  logic [PW:0] rptr_q, rptr_d;
  logic [PW:0] rlevel_q, rlevel_d;
  logic        rempty_q, rempty_d;
  logic        rae_q, rae_d;
  logic        rvalid_q, rvalid_d;
  logic        runder_q, runder_d;
  logic        rd_ok;
  logic [PW:0] wbin;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    wbin     = '0;
    wbin[PW] = bus.rq2_wptr[PW];
    for (int i = PW - 1; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ bus.rq2_wptr[i];
    end
  end

  // Accept uses the registered empty flag, so a read can never race a
  // write pointer that has only just arrived.
  assign rd_ok = bus.rinc & ~rempty_q;

  always_comb begin
    rbin_d   = rbin_q + {{PW{1'b0}}, rd_ok};
    rptr_d   = rbin_d ^ (rbin_d >> 1);
    rlevel_d = wbin - rbin_d;
    rempty_d = (rptr_d == bus.rq2_wptr);
    rae_d    = (rlevel_d <= AE_LIMIT);
    rvalid_d = rd_ok;
    runder_d = runder_q | (bus.rinc & rempty_q);
  end

  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q   <= '0;
      rptr_q   <= '0;
      rlevel_q <= '0;
      rempty_q <= 1'b1;
      rae_q    <= 1'b1;
      rvalid_q <= 1'b0;
      runder_q <= 1'b0;
    end else begin
      rbin_q   <= rbin_d;
      rptr_q   <= rptr_d;
      rlevel_q <= rlevel_d;
      rempty_q <= rempty_d;
      rae_q    <= rae_d;
      rvalid_q <= rvalid_d;
      runder_q <= runder_d;
    end
  end

  assign bus.raddr         = rbin_q[PW-1:0];
  assign bus.rptr          = rptr_q;
  assign bus.rempty        = rempty_q;
  assign bus.ralmost_empty = rae_q;
  assign bus.rlevel        = rlevel_q;
  assign bus.rvalid        = rvalid_q;
  assign bus.runderflow    = runder_q;

endmodule

// File: tb/tb_rptr_handler.sv
// tb/tb_rptr_handler.sv - self-checking bench for rptr_handler
module tb_rptr_handler;

  logic rclk = 1'b0;
  logic rrst = 1'b1;

  always #5 rclk = ~rclk;

  rptr_handler_if #(.PTR_WIDTH(3)) rif ();

  rptr_handler #(.PTR_WIDTH(3), .AE_THRESH(2)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (rif)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: counts of words written and read, plus status bits.
  int m_wr, m_rd;
  bit m_empty, m_ae, m_valid, m_uf;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] to_gray(input int v);
    int w;
    w = v % 16;
    return 4'(w ^ (w / 2));
  endfunction

  task automatic set_wr(input int w);
    m_wr = w;
    rif.rq2_wptr = to_gray(w);
  endtask

  task automatic model_reset();
    m_wr = 0; m_rd = 0;
    m_empty = 1; m_ae = 1; m_valid = 0; m_uf = 0;
  endtask

  task automatic check_all(input string tag);
    check_eq({tag, ".raddr"},  32'(rif.raddr),         32'(m_rd % 8));
    check_eq({tag, ".rptr"},   32'(rif.rptr),          32'(to_gray(m_rd)));
    check_eq({tag, ".rlevel"}, 32'(rif.rlevel),        32'(m_wr - m_rd));
    check_eq({tag, ".rempty"}, 32'(rif.rempty),        32'(m_empty));
    check_eq({tag, ".ae"},     32'(rif.ralmost_empty), 32'(m_ae));
    check_eq({tag, ".rvalid"}, 32'(rif.rvalid),        32'(m_valid));
    check_eq({tag, ".uflow"},  32'(rif.runderflow),    32'(m_uf));
  endtask

  // One clock with the given read request; model follows the edge.
  task automatic step(input bit inc, input string tag);
    logic [3:0] prev_ptr;
    bit acc;
    int lvl;
    rif.rinc = inc;
    prev_ptr = rif.rptr;
    @(posedge rclk);
    #1;
    acc = inc && !m_empty;
    if (inc && m_empty) m_uf = 1;
    if (acc) m_rd++;
    lvl = m_wr - m_rd;
    m_empty = (lvl == 0);
    m_ae = (lvl <= 2);
    m_valid = acc;
    check_all(tag);
    check_eq({tag, ".hamming_le1"}, 32'($countones(prev_ptr ^ rif.rptr) <= 1), 32'd1);
  endtask

  initial begin
    rif.rinc = 1'b0;
    rif.rq2_wptr = '0;
    model_reset();
    repeat (2) @(posedge rclk);
    #1;
    check_all("reset");
    #3 rrst = 1'b0;

    // Basic read of three words.
    set_wr(3);
    step(0, "t1.wr3");
    for (int i = 0; i < 3; i++) step(1, "t1.rd");
    check_eq("t1.rptr_final", 32'(rif.rptr), 32'h2);
    step(0, "t1.valid_off");

    // Underflow, sticky after rinc drops.
    step(1, "t3.uf1");
    check_eq("t3.uf_set", 32'(rif.runderflow), 32'd1);
    step(1, "t3.uf2");
    step(0, "t3.hold");
    step(0, "t3.hold2");

    // Async reset between edges, with nonzero state.
    set_wr(5);
    step(0, "t5.pre");
    step(1, "t5.pre_rd");
    step(1, "t5.pre_rd2");
    #3 rrst = 1'b1;
    #1;
    check_eq("t5.raddr",  32'(rif.raddr), 32'd0);
    check_eq("t5.rptr",   32'(rif.rptr), 32'd0);
    check_eq("t5.rlevel", 32'(rif.rlevel), 32'd0);
    check_eq("t5.rempty", 32'(rif.rempty), 32'd1);
    check_eq("t5.ae",     32'(rif.ralmost_empty), 32'd1);
    check_eq("t5.rvalid", 32'(rif.rvalid), 32'd0);
    check_eq("t5.uflow",  32'(rif.runderflow), 32'd0);
    model_reset();
    rif.rinc = 1'b0;
    set_wr(0);
    #2 rrst = 1'b0;
    set_wr(1);
    step(0, "t5.wr1");
    step(1, "t5.rd1");
    check_eq("t5.raddr_after", 32'(rif.raddr), 32'd1);

    // Wrap and full level (reset first so rbin starts at 0).
    @(negedge rclk);
    rrst = 1'b1;
    #1;
    model_reset();
    set_wr(0);
    @(negedge rclk);
    rrst = 1'b0;
    set_wr(8);
    step(0, "t2.full");
    check_eq("t2.level8", 32'(rif.rlevel), 32'd8);
    for (int i = 0; i < 8; i++) step(1, "t2.rd");
    check_eq("t2.rptr_wrap", 32'(rif.rptr), 32'hC);
    check_eq("t2.raddr_wrap", 32'(rif.raddr), 32'd0);
    set_wr(9);
    step(0, "t2.wr9");
    step(1, "t2.rd9");
    check_eq("t2.rptr_9", 32'(rif.rptr), 32'hD);
    check_eq("t2.raddr_9", 32'(rif.raddr), 32'd1);

    // Simultaneous read and write-pointer change.
    set_wr(10);
    step(0, "t4.lvl1");
    set_wr(11);
    step(1, "t4.both");
    check_eq("t4.level", 32'(rif.rlevel), 32'd1);
    check_eq("t4.rempty", 32'(rif.rempty), 32'd0);

    // Randomised traffic with a monotonic write pointer.
    for (int c = 0; c < 1000; c++) begin
      if ((m_wr - m_rd) < 8 && $urandom_range(0, 1) == 1) set_wr(m_wr + 1);
      step(1'($urandom_range(0, 1)), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
